// File: rtl/vending_machine_param.sv
// Parametrised vending controller: multi-coin or online payment, per-product stock, change return.
// Optional inactivity-timeout refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vending_machine_param #(
    parameter int NUM_PRODUCTS   = 8,
    parameter int SEL_W          = 3,
    parameter int AMT_W          = 8,
    parameter int PRICE_BASE     = 20,
    parameter int PRICE_STEP     = 5,
    parameter int STOCK_W        = 4,
    parameter int INIT_STOCK     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic               cancel,
    input  logic [SEL_W-1:0]   product_sel,
    input  logic               coin_valid,
    input  logic [AMT_W-1:0]   coin_value,
    input  logic               online_payment,
    input  logic               restock,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [2:0]         state,
    output logic [AMT_W-1:0]   product_price,
    output logic [AMT_W-1:0]   credit,
    output logic               dispense_product,
    output logic [SEL_W-1:0]   dispensed_id,
    output logic [AMT_W-1:0]   return_change,
    output logic               change_valid,
    output logic               sold_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_COLLECT  = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4,
        S_REFUND   = 3'd5
    } state_t;

    localparam logic [SEL_W:0] NUM_P = NUM_PRODUCTS[SEL_W:0];

    function automatic logic [AMT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        price_of = AMT_W'(PRICE_BASE + int'(idx) * PRICE_STEP);
    endfunction

    state_t             state_r;
    logic [SEL_W-1:0]   sel_r;
    logic [AMT_W-1:0]   change_r;
    logic [STOCK_W-1:0] stock_r [NUM_PRODUCTS];

    logic               sel_ok_s;
    logic [AMT_W:0]     coin_sum_s;
    logic [AMT_W-1:0]   credit_next_s;
    logic [AMT_W-1:0]   refund_amt_s;
    logic [STOCK_W:0]   restock_sum_s;
    logic [STOCK_W-1:0] restock_sat_s;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt_r;
`endif

    assign state = state_r;

    // Saturating credit/stock arithmetic and refund amount for the current cycle.
    always_comb begin
        sel_ok_s   = ({1'b0, product_sel} < NUM_P);
        coin_sum_s = {1'b0, credit} + {1'b0, coin_value};
        if (coin_sum_s[AMT_W]) begin
            credit_next_s = '1;
        end else begin
            credit_next_s = coin_sum_s[AMT_W-1:0];
        end
        if (coin_valid) begin
            refund_amt_s = credit_next_s;
        end else begin
            refund_amt_s = credit;
        end
        restock_sum_s = {1'b0, stock_r[product_sel]} + {1'b0, restock_qty};
        if (restock_sum_s[STOCK_W]) begin
            restock_sat_s = '1;
        end else begin
            restock_sat_s = restock_sum_s[STOCK_W-1:0];
        end
    end

    // Transaction FSM with stock bookkeeping; all outputs registered here.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r          <= S_IDLE;
            sel_r            <= '0;
            change_r         <= '0;
            product_price    <= '0;
            credit           <= '0;
            dispense_product <= 1'b0;
            dispensed_id     <= '0;
            return_change    <= '0;
            change_valid     <= 1'b0;
            sold_out         <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock_r[i] <= STOCK_W'(INIT_STOCK);
            end
`ifdef VEND_TIMEOUT_EN
            idle_cnt_r       <= '0;
`endif
        end else begin
            dispense_product <= 1'b0;
            dispensed_id     <= '0;
            change_valid     <= 1'b0;
            return_change    <= '0;
            sold_out         <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        if (sel_ok_s) begin
                            if (stock_r[product_sel] != '0) begin
                                sel_r         <= product_sel;
                                product_price <= price_of(product_sel);
                                state_r       <= S_SELECT;
                            end else begin
                                sold_out <= 1'b1;
                            end
                        end
                    end else if (restock && sel_ok_s) begin
                        stock_r[product_sel] <= restock_sat_s;
                    end
                end
                S_SELECT: begin
                    state_r <= S_COLLECT;
`ifdef VEND_TIMEOUT_EN
                    idle_cnt_r <= '0;
`endif
                end
                S_COLLECT: begin
                    if (cancel) begin
                        // A coin landing with cancel is folded into the refund.
                        credit        <= refund_amt_s;
                        change_valid  <= (refund_amt_s != '0);
                        return_change <= refund_amt_s;
                        state_r       <= S_REFUND;
                    end else if (online_payment) begin
                        change_r         <= credit;
                        dispense_product <= 1'b1;
                        dispensed_id     <= sel_r;
                        state_r          <= S_DISPENSE;
                    end else if (coin_valid) begin
                        credit <= credit_next_s;
`ifdef VEND_TIMEOUT_EN
                        idle_cnt_r <= '0;
`endif
                        if (credit_next_s >= product_price) begin
                            change_r         <= credit_next_s - product_price;
                            dispense_product <= 1'b1;
                            dispensed_id     <= sel_r;
                            state_r          <= S_DISPENSE;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (idle_cnt_r == TO_LAST) begin
                        change_valid  <= (credit != '0);
                        return_change <= credit;
                        state_r       <= S_REFUND;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + TO_W'(1);
                    end
`endif
                end
                S_DISPENSE: begin
                    stock_r[sel_r] <= stock_r[sel_r] - STOCK_W'(1);
                    change_valid   <= (change_r != '0);
                    return_change  <= change_r;
                    state_r        <= S_CHANGE;
                end
                S_CHANGE: begin
                    credit        <= '0;
                    product_price <= '0;
                    change_r      <= '0;
                    state_r       <= S_IDLE;
                end
                S_REFUND: begin
                    credit        <= '0;
                    product_price <= '0;
                    state_r       <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: expected pulses (kind, value, cycle) are queued
// when stimulus is driven and compared when dispense/change/sold_out pulses appear.
module tb_vending_machine_param;

    localparam int K_DISP = 0;
    localparam int K_CHG  = 1;
    localparam int K_SOLD = 2;

    logic       clock = 1'b0;
    logic       rst;
    logic       start;
    logic       cancel;
    logic [2:0] product_sel;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       online_payment;
    logic       restock;
    logic [3:0] restock_qty;
    logic [2:0] state;
    logic [7:0] product_price;
    logic [7:0] credit;
    logic       dispense_product;
    logic [2:0] dispensed_id;
    logic [7:0] return_change;
    logic       change_valid;
    logic       sold_out;

    typedef struct {
        int kind;
        int value;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    vending_machine_param dut (
        .clock            (clock),
        .rst              (rst),
        .start            (start),
        .cancel           (cancel),
        .product_sel      (product_sel),
        .coin_valid       (coin_valid),
        .coin_value       (coin_value),
        .online_payment   (online_payment),
        .restock          (restock),
        .restock_qty      (restock_qty),
        .state            (state),
        .product_price    (product_price),
        .credit           (credit),
        .dispense_product (dispense_product),
        .dispensed_id     (dispensed_id),
        .return_change    (return_change),
        .change_valid     (change_valid),
        .sold_out         (sold_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int value, input int at);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic take_pulse(input int kind, input int value);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_pulse", kind, 99);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_value", value, e.value);
            check("pulse_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clock) begin
        if (dispense_product) take_pulse(K_DISP, int'(dispensed_id));
        if (change_valid) take_pulse(K_CHG, int'(return_change));
        if (sold_out) take_pulse(K_SOLD, 0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_txn(input int sel);
        product_sel = 3'(sel);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("state_select", state, 1);
        tick();
    endtask

    task automatic drop_coin(input int v);
        coin_valid = 1'b1;
        coin_value = 8'(v);
        tick();
        coin_valid = 1'b0;
        coin_value = 8'd0;
    endtask

    task automatic finish_vend();
        check("state_dispense", state, 3);
        tick();
        check("state_change", state, 4);
        tick();
        check("state_idle", state, 0);
    endtask

    task automatic buy_exact(input int sel, input int price);
        begin_txn(sel);
        push_ev(K_DISP, sel, cyc + 1);
        drop_coin(price);
        finish_vend();
    endtask

    task automatic expect_sold_out(input int sel);
        push_ev(K_SOLD, 0, cyc + 1);
        product_sel = 3'(sel);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sold_out_state", state, 0);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_price"}, product_price, 0);
        check({tag, "_credit"}, credit, 0);
        check({tag, "_disp"}, dispense_product, 0);
        check({tag, "_chg"}, change_valid, 0);
        check({tag, "_ret"}, return_change, 0);
        check({tag, "_sold"}, sold_out, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cancel = 1'b0; product_sel = 3'd0;
        coin_valid = 1'b0; coin_value = 8'd0; online_payment = 1'b0;
        restock = 1'b0; restock_qty = 4'd0;
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b1;
        tick();

        // Three 10-coins for a 25-price product, change 5.
        begin_txn(1);
        check("price_1", product_price, 25);
        check("state_collect", state, 2);
        drop_coin(10);
        drop_coin(10);
        check("credit_20", credit, 20);
        push_ev(K_DISP, 1, cyc + 1);
        push_ev(K_CHG, 5, cyc + 2);
        drop_coin(10);
        finish_vend();
        check("price_cleared", product_price, 0);
        check("credit_cleared", credit, 0);
        buy_exact(1, 25);
        expect_sold_out(1);

        // Online payment, no coins: dispense without change.
        begin_txn(5);
        check("price_5", product_price, 45);
        push_ev(K_DISP, 5, cyc + 1);
        online_payment = 1'b1;
        tick();
        online_payment = 1'b0;
        finish_vend();

        // Online payment after a coin returns the coin credit.
        begin_txn(0);
        drop_coin(10);
        push_ev(K_DISP, 0, cyc + 1);
        push_ev(K_CHG, 10, cyc + 2);
        online_payment = 1'b1;
        tick();
        online_payment = 1'b0;
        finish_vend();

        // Cancel with a coin in the same cycle refunds both.
        begin_txn(3);
        drop_coin(10);
        check("credit_10", credit, 10);
        push_ev(K_CHG, 15, cyc + 1);
        cancel = 1'b1;
        coin_valid = 1'b1;
        coin_value = 8'd5;
        tick();
        cancel = 1'b0;
        coin_valid = 1'b0;
        coin_value = 8'd0;
        check("state_refund", state, 5);
        check("credit_refund", credit, 15);
        tick();
        check("refund_idle", state, 0);
        check("refund_credit_clr", credit, 0);
        check("refund_price_clr", product_price, 0);

        // Sell out product 2, restock 3, then three more sales.
        buy_exact(2, 30);
        buy_exact(2, 30);
        expect_sold_out(2);
        product_sel = 3'd2;
        restock = 1'b1;
        restock_qty = 4'd3;
        tick();
        restock = 1'b0;
        restock_qty = 4'd0;
        for (int i = 0; i < 3; i++) buy_exact(2, 30);
        expect_sold_out(2);

        // Credit saturates at 255: 10 + 250 -> 255, change 255 - 55.
        begin_txn(7);
        drop_coin(10);
        push_ev(K_DISP, 7, cyc + 1);
        push_ev(K_CHG, 200, cyc + 2);
        drop_coin(250);
        finish_vend();

        // Inactivity in COLLECT.
        begin_txn(0);
        drop_coin(10);
`ifdef VEND_TIMEOUT_EN
        push_ev(K_CHG, 10, cyc + 16);
        repeat (20) tick();
        check("timeout_idle", state, 0);
`else
        repeat (100) tick();
        check("no_timeout_state", state, 2);
        check("no_timeout_credit", credit, 10);
        push_ev(K_CHG, 10, cyc + 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        check("cancel_idle", state, 0);
`endif

        // Reset mid-COLLECT discards credit and restores stock.
        begin_txn(4);
        drop_coin(10);
        drop_coin(10);
        check("credit_pre_reset", credit, 20);
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        rst = 1'b1;
        tick();
        check("post_reset_state", state, 0);
        buy_exact(2, 30);
        buy_exact(2, 30);
        expect_sold_out(2);

        repeat (3) tick();
        check("pending_events", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the single-shot vending controller.
- Configurable product count and per-product stock counters.
- Accepts multi-coin credit accumulation or online payment; computes and returns change.
- Sits between the coin/keypad front end and the dispenser/changer actuators. Optional inactivity-timeout refund.

Parameters:
NUM_PRODUCTS, 8, number of selectable products (2..16)
SEL_W, 3, product_sel width; 2**SEL_W >= NUM_PRODUCTS
AMT_W, 8, width of coin_value, product_price, credit, return_change
PRICE_BASE, 20, price of product 0
PRICE_STEP, 5, price increment per product index: price(i) = PRICE_BASE + i*PRICE_STEP
STOCK_W, 4, per-product stock counter width
INIT_STOCK, 2, stock loaded into every product on reset
TIMEOUT_CYCLES, 16, inactivity limit in COLLECT (used only with VEND_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin transaction with product_sel (sampled in IDLE)
cancel  in  1  abort transaction, refund credit
product_sel  in  SEL_W  product index
coin_valid  in  1  one coin this cycle
coin_value  in  AMT_W  value of the coin
online_payment  in  1  product paid externally
restock  in  1  add restock_qty to stock[product_sel] (IDLE only)
restock_qty  in  STOCK_W  restock amount
state  out  3  current FSM state code
product_price  out  AMT_W  latched price of selected product, 0 in IDLE
credit  out  AMT_W  accumulated coin credit
dispense_product  out  1  one-cycle dispense pulse
dispensed_id  out  SEL_W  product index being dispensed
return_change  out  AMT_W  change/refund amount, valid with change_valid
change_valid  out  1  one-cycle change pulse
sold_out  out  1  one-cycle pulse: start on empty product

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; credit 0; every stock counter = INIT_STOCK.
- States: IDLE=0, SELECT=1, COLLECT=2, DISPENSE=3, CHANGE=4, REFUND=5.
- All outputs are registered.
- IDLE, start=1, product_sel<NUM_PRODUCTS, stock>0:
  - Latch sel and price(sel).
  - Go to SELECT.
- IDLE, start=1, stock==0: pulse sold_out for one cycle; stay in IDLE.
- IDLE, start=1, sel>=NUM_PRODUCTS: ignore.
- IDLE, restock=1 (start=0): stock[sel] += restock_qty, saturating at 2**STOCK_W-1. restock is ignored outside IDLE, and ignored in IDLE when start=1.
- SELECT: one cycle, then COLLECT. product_price holds from SELECT until the return to IDLE.
- COLLECT, priority cancel > online_payment > coin:
  - cancel: go to REFUND. A coin in the same cycle is added to the refund.
  - online_payment: go to DISPENSE. All coin credit is returned as change.
  - coin_valid: credit_next = credit + coin_value, saturating at 2**AMT_W-1.
  - If credit_next >= price: go to DISPENSE on the same edge.
- DISPENSE (one cycle):
  - dispense_product=1, dispensed_id=sel.
  - stock[sel] decrements.
  - change = credit - price (coin path) or credit (online path).
  - Then go to CHANGE.
- CHANGE (one cycle):
  - If change != 0: change_valid=1, return_change=change. If change == 0: no pulse.
  - Clear credit and product_price; go to IDLE.
- REFUND (one cycle):
  - If credit != 0: change_valid=1, return_change=credit.
  - Clear credit; go to IDLE.
- Latency: final coin at edge N → dispense_product high in cycle N+1 → change_valid in cycle N+2.
- start while not in IDLE is ignored. Reset mid-transaction discards credit with no refund pulse.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined:
  - An inactivity counter runs in COLLECT; it clears on entry to COLLECT and on every coin_valid.
  - On reaching TIMEOUT_CYCLES with no coin, go to REFUND.
  - A coin arriving in the timeout cycle wins: it is accumulated and the counter clears.
- Undefined: no counter; COLLECT waits indefinitely for coin, cancel or online_payment.

Test Plan:
- sel=1 (price 25), coins 10,10,10 on consecutive cycles → dispense_product high one cycle after third coin, dispensed_id=1; next cycle change_valid=1, return_change=5; stock[1] 2→1.
- sel=5 (price 45), online_payment=1 in COLLECT, no coins → dispense_product pulse, no change_valid, state back to 0.
- sel=3 (price 35), coin 10, then cancel with coin 5 in the same cycle → REFUND, change_valid=1, return_change=15, no dispense.
- sel=2 bought twice with exact coin 30 → third start gives sold_out pulse, state stays 0; restock qty=3 in IDLE → purchase succeeds, stock 3→2.
- VEND_TIMEOUT_EN, sel=0, coin 10 then idle → REFUND after 16 idle cycles, return_change=10. Without the macro: still in COLLECT after 100 cycles.
- Reset asserted mid-COLLECT with credit 20 → all outputs 0 immediately, state=0, stock back to 2, no change_valid.
